// File: rtl/seg_display_driver_if.sv
// seg_display_driver_if
//   Groups the game-facing inputs and the display outputs of
//   seg_display_driver so the driver and its user share one bundle.
//
//   select    : game phase (0 mode pick, 1 target, 2 counting, 3 score)
//   mode      : difficulty (0 easy, 1 regular, 2 hard, 3 same as hard)
//   number    : unsigned value to display
//   seg       : cathodes {g,f,e,d,c,b,a}, active-low
//   dp        : decimal point, active-low, always off
//   an        : digit anodes, active-low, an[0] is the rightmost digit
//   dbg_conv  : 1 while the binary-to-BCD converter is busy
//   dbg_value : binary value whose BCD image is currently displayed
//
// There is no valid/ready handshake on this bundle: number is level-sampled,
// and any difference from the displayed value is picked up whenever the
// converter is idle. Intermediate values that come and go while it is busy
// are never displayed.
interface seg_display_driver_if;
   logic [1:0]  select;
   logic [1:0]  mode;
   logic [13:0] number;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        dbg_conv;
   logic [13:0] dbg_value;

   modport master (
      output select, mode, number,
      input  seg, dp, an, dbg_conv, dbg_value
   );

   modport slave (
      input  select, mode, number,
      output seg, dp, an, dbg_conv, dbg_value
   );
endinterface

// File: rtl/seg_display_driver.sv
// seg_display_driver
//   Four-digit multiplexed seven-segment driver for the reaction game.
//   The input number is clamped to 9999 and converted to BCD by a
//   sequential shift-and-add-3 converter (14 iterations, one per clock).
//   Only a fully converted value is ever displayed. A refresh counter
//   scans the four digits; in the score phase the display blinks.
//
//   clk : system clock, everything on its rising edge
//   rst : synchronous, active-low reset
//   bus : seg_display_driver_if.slave (select, mode, number in;
//         seg, dp, an, dbg_conv, dbg_value out)
module seg_display_driver #(
   parameter int REFRESH_TICKS = 100000,
   parameter int BLINK_TICKS   = 25000000
) (
   input logic                 clk,
   input logic                 rst,
   seg_display_driver_if.slave bus
);

   localparam int RW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_TICKS - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

   typedef enum logic {IDLE, CONV} conv_state_t;

   conv_state_t state_q, state_d;
   logic [29:0] work_q, work_d;     // {bcd[15:0], remaining binary[13:0]}
   logic [29:0] work_adj;
   logic [29:0] work_shift;
   logic [3:0]  iter_q, iter_d;
   logic [13:0] src_q, src_d;       // value being converted
   logic [13:0] value_q, value_d;   // value whose BCD is on the display
   logic [15:0] bcd_q, bcd_d;       // committed BCD, the only thing shown
   logic [13:0] clamped;

   logic [RW-1:0] ref_cnt;
   logic [1:0]    digit_idx;
   logic [BW-1:0] blink_cnt;
   logic          blink_off;

   assign clamped = (bus.number > 14'd9999) ? 14'd9999 : bus.number;

   // Converter state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         work_q  <= '0;
         iter_q  <= '0;
         src_q   <= '0;
         value_q <= '0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         iter_q  <= iter_d;
         src_q   <= src_d;
         value_q <= value_d;
         bcd_q   <= bcd_d;
      end
   end

   // Converter next state: adjust every BCD nibble >= 5, then shift left.
   always_comb begin
      state_d  = state_q;
      work_d   = work_q;
      iter_d   = iter_q;
      src_d    = src_q;
      value_d  = value_q;
      bcd_d    = bcd_q;
      work_adj = work_q;
      for (int i = 0; i < 4; i++) begin
         if (work_q[14 + 4*i +: 4] >= 4'd5) begin
            work_adj[14 + 4*i +: 4] = work_q[14 + 4*i +: 4] + 4'd3;
         end
      end
      work_shift = {work_adj[28:0], 1'b0};

      case (state_q)
         IDLE: begin
            if (clamped != value_q) begin
               src_d   = clamped;
               work_d  = {16'd0, clamped};
               iter_d  = 4'd0;
               state_d = CONV;
            end
         end
         CONV: begin
            work_d = work_shift;
            iter_d = iter_q + 4'd1;
            // 14th iteration: result and its source commit together
            if (iter_q == 4'd13) begin
               bcd_d   = work_shift[29:14];
               value_d = src_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Digit scan and blink timing
   always_ff @(posedge clk) begin
      if (!rst) begin
         ref_cnt   <= '0;
         digit_idx <= 2'd0;
         blink_cnt <= '0;
         blink_off <= 1'b0;
      end else begin
         if (ref_cnt == REF_LAST) begin
            ref_cnt   <= '0;
            digit_idx <= digit_idx + 2'd1;
         end else begin
            ref_cnt <= ref_cnt + RW'(1);
         end
         // Held in the on phase outside the score screen so that
         // entering it always starts visible.
         if (bus.select != 2'd3) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
         end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end
   end

   function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
      case (d)
         4'd0:    digit_to_seg = 7'b1000000;
         4'd1:    digit_to_seg = 7'b1111001;
         4'd2:    digit_to_seg = 7'b0100100;
         4'd3:    digit_to_seg = 7'b0110000;
         4'd4:    digit_to_seg = 7'b0011001;
         4'd5:    digit_to_seg = 7'b0010010;
         4'd6:    digit_to_seg = 7'b0000010;
         4'd7:    digit_to_seg = 7'b1111000;
         4'd8:    digit_to_seg = 7'b0000000;
         4'd9:    digit_to_seg = 7'b0010000;
         default: digit_to_seg = 7'b1111111;
      endcase
   endfunction

   logic [3:0] nib;
   logic       blank;
   logic [3:0] mode_digit;

   // Output decode; select/mode act combinationally on the scan state.
   always_comb begin
      nib        = 4'd0;
      blank      = 1'b0;
      mode_digit = (bus.mode == 2'd3) ? 4'd3 : {2'b00, bus.mode} + 4'd1;
      bus.seg    = 7'b1111111;
      bus.an     = 4'b1111;
      case (digit_idx)
         2'd0: nib = bcd_q[3:0];
         2'd1: begin
            nib   = bcd_q[7:4];
            blank = (bcd_q[15:4] == 12'd0);
         end
         2'd2: begin
            nib   = bcd_q[11:8];
            blank = (bcd_q[15:8] == 8'd0);
         end
         default: begin
            nib   = bcd_q[15:12];
            blank = (bcd_q[15:12] == 4'd0);
         end
      endcase

      if (bus.select == 2'd0) begin
         bus.seg = (digit_idx == 2'd0) ? digit_to_seg(mode_digit) : 7'b0111111;
      end else if (!blank) begin
         bus.seg = digit_to_seg(nib);
      end

      if (rst && !((bus.select == 2'd3) && blink_off)) begin
         bus.an = ~(4'b0001 << digit_idx);
      end
   end

   assign bus.dp        = 1'b1;
   assign bus.dbg_conv  = (state_q == CONV);
   assign bus.dbg_value = value_q;

endmodule
